// File: rtl/riscv_pipelined_datapath.sv
// Five-stage RV32I integer-subset pipeline (IF/ID/EX/MEM/WB) with forwarding,
// load-use stall and EX-resolved branches; instruction/data memories are external.
module riscv_pipelined_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instruction,
    output logic [31:0] PC,
    output logic [31:0] dAddress,
    output logic [31:0] dWriteData,
    input  logic [31:0] dReadData,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] RO1,
    output logic [31:0] WriteBackData
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
        ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    beq;
        logic    bne;
        logic    use_imm;
        alu_op_e alu_op;
    } ctrl_t;

    logic [XLEN-1:0] ifid_instr, ifid_pc;
    logic [XLEN-1:0] idex_pc, idex_a, idex_b, idex_imm;
    logic [4:0]      idex_rs1, idex_rs2, idex_rd;
    ctrl_t           idex_ctrl;
    logic [XLEN-1:0] exmem_alu, exmem_store;
    logic [4:0]      exmem_rd;
    logic            exmem_reg_write, exmem_mem_read, exmem_mem_write;
    logic [XLEN-1:0] memwb_alu, memwb_load;
    logic [4:0]      memwb_rd;
    logic            memwb_reg_write, memwb_mem_to_reg;
    logic [XLEN-1:0] regs [0:31];

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    ctrl_t           dec_ctrl;
    logic [XLEN-1:0] dec_imm, rs1_val, rs2_val;
    logic            uses_rs1, uses_rs2, load_use, taken;
    logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res;

    assign opcode = ifid_instr[6:0];
    assign rd     = ifid_instr[11:7];
    assign funct3 = ifid_instr[14:12];
    assign rs1    = ifid_instr[19:15];
    assign rs2    = ifid_instr[24:20];
    assign funct7 = ifid_instr[31:25];

    assign WriteBackData = memwb_mem_to_reg ? memwb_load : memwb_alu;
    assign dAddress      = exmem_alu;
    assign dWriteData    = exmem_store;
    assign MemRead       = exmem_mem_read;
    assign MemWrite      = exmem_mem_write;
    assign RO1           = rs1_val;

    // Decode: unsupported encodings fall through with all control cleared (NOP)
    always_comb begin
        dec_ctrl = '0;
        dec_imm  = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_ctrl.reg_write = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                case ({funct7, funct3})
                    {7'h00, 3'b000}: dec_ctrl.alu_op = ALU_ADD;
                    {7'h20, 3'b000}: dec_ctrl.alu_op = ALU_SUB;
                    {7'h00, 3'b001}: dec_ctrl.alu_op = ALU_SLL;
                    {7'h00, 3'b010}: dec_ctrl.alu_op = ALU_SLT;
                    {7'h00, 3'b011}: dec_ctrl.alu_op = ALU_SLTU;
                    {7'h00, 3'b100}: dec_ctrl.alu_op = ALU_XOR;
                    {7'h00, 3'b101}: dec_ctrl.alu_op = ALU_SRL;
                    {7'h20, 3'b101}: dec_ctrl.alu_op = ALU_SRA;
                    {7'h00, 3'b110}: dec_ctrl.alu_op = ALU_OR;
                    {7'h00, 3'b111}: dec_ctrl.alu_op = ALU_AND;
                    default: begin
                        dec_ctrl = '0;
                        uses_rs1 = 1'b0;
                        uses_rs2 = 1'b0;
                    end
                endcase
            end
            7'b0010011: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.use_imm   = 1'b1;
                dec_imm  = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
                uses_rs1 = 1'b1;
                case (funct3)
                    3'b000: dec_ctrl.alu_op = ALU_ADD;
                    3'b010: dec_ctrl.alu_op = ALU_SLT;
                    3'b011: dec_ctrl.alu_op = ALU_SLTU;
                    3'b100: dec_ctrl.alu_op = ALU_XOR;
                    3'b110: dec_ctrl.alu_op = ALU_OR;
                    3'b111: dec_ctrl.alu_op = ALU_AND;
                    3'b001: dec_ctrl.alu_op = ALU_SLL;
                    default: dec_ctrl.alu_op = (funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
                endcase
                if ((funct3 == 3'b001 && funct7 != 7'h00) ||
                    (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)) begin
                    dec_ctrl = '0;
                    uses_rs1 = 1'b0;
                end
            end
            7'b0000011: if (funct3 == 3'b010) begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.mem_read  = 1'b1;
                dec_ctrl.use_imm   = 1'b1;
                dec_imm  = {{20{ifid_instr[31]}}, ifid_instr[31:20]};
                uses_rs1 = 1'b1;
            end
            7'b0100011: if (funct3 == 3'b010) begin
                dec_ctrl.mem_write = 1'b1;
                dec_ctrl.use_imm   = 1'b1;
                dec_imm  = {{20{ifid_instr[31]}}, ifid_instr[31:25], ifid_instr[11:7]};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b1100011: if (funct3 == 3'b000 || funct3 == 3'b001) begin
                dec_ctrl.beq    = (funct3 == 3'b000);
                dec_ctrl.bne    = (funct3 == 3'b001);
                dec_ctrl.alu_op = ALU_SUB;
                dec_imm  = {{19{ifid_instr[31]}}, ifid_instr[31], ifid_instr[7],
                            ifid_instr[30:25], ifid_instr[11:8], 1'b0};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0110111: begin
                dec_ctrl.reg_write = 1'b1;
                dec_ctrl.use_imm   = 1'b1;
                dec_ctrl.alu_op    = ALU_LUI;
                dec_imm = {ifid_instr[31:12], 12'h000};
            end
            default: ;
        endcase
    end

    // Register-file read with same-cycle write-back bypass
    always_comb begin
        rs1_val = regs[rs1];
        rs2_val = regs[rs2];
        if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs1) rs1_val = WriteBackData;
        if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == rs2) rs2_val = WriteBackData;
        if (rs1 == 5'd0) rs1_val = '0;
        if (rs2 == 5'd0) rs2_val = '0;
    end

    assign load_use = idex_ctrl.mem_read &&
                      ((uses_rs1 && rs1 == idex_rd) || (uses_rs2 && rs2 == idex_rd));

    // EX operand forwarding; load results in EX/MEM are not yet available
    always_comb begin
        fwd_a = idex_a;
        fwd_b = idex_b;
        if (exmem_reg_write && !exmem_mem_read && exmem_rd != 5'd0 && exmem_rd == idex_rs1)
            fwd_a = exmem_alu;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs1)
            fwd_a = WriteBackData;
        if (exmem_reg_write && !exmem_mem_read && exmem_rd != 5'd0 && exmem_rd == idex_rs2)
            fwd_b = exmem_alu;
        else if (memwb_reg_write && memwb_rd != 5'd0 && memwb_rd == idex_rs2)
            fwd_b = WriteBackData;
    end

    assign op_b  = idex_ctrl.use_imm ? idex_imm : fwd_b;
    assign taken = (idex_ctrl.beq && fwd_a == fwd_b) || (idex_ctrl.bne && fwd_a != fwd_b);

    always_comb begin
        alu_res = '0;
        case (idex_ctrl.alu_op)
            ALU_ADD:  alu_res = fwd_a + op_b;
            ALU_SUB:  alu_res = fwd_a - op_b;
            ALU_AND:  alu_res = fwd_a & op_b;
            ALU_OR:   alu_res = fwd_a | op_b;
            ALU_XOR:  alu_res = fwd_a ^ op_b;
            ALU_SLT:  alu_res = XLEN'($signed(fwd_a) < $signed(op_b));
            ALU_SLTU: alu_res = XLEN'(fwd_a < op_b);
            ALU_SLL:  alu_res = fwd_a << op_b[4:0];
            ALU_SRL:  alu_res = fwd_a >> op_b[4:0];
            ALU_SRA:  alu_res = XLEN'($signed(fwd_a) >>> op_b[4:0]);
            ALU_LUI:  alu_res = op_b;
            default:  alu_res = '0;
        endcase
    end

    // Pipeline registers; a taken branch overrides a coincident load-use stall
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC               <= RESET_PC;
            ifid_instr       <= NOP;
            ifid_pc          <= '0;
            idex_pc          <= '0;
            idex_a           <= '0;
            idex_b           <= '0;
            idex_imm         <= '0;
            idex_rs1         <= '0;
            idex_rs2         <= '0;
            idex_rd          <= '0;
            idex_ctrl        <= '0;
            exmem_alu        <= '0;
            exmem_store      <= '0;
            exmem_rd         <= '0;
            exmem_reg_write  <= 1'b0;
            exmem_mem_read   <= 1'b0;
            exmem_mem_write  <= 1'b0;
            memwb_alu        <= '0;
            memwb_load       <= '0;
            memwb_rd         <= '0;
            memwb_reg_write  <= 1'b0;
            memwb_mem_to_reg <= 1'b0;
        end else begin
            if (taken) begin
                PC         <= idex_pc + idex_imm;
                ifid_instr <= NOP;
                ifid_pc    <= '0;
            end else if (!load_use) begin
                PC         <= PC + 32'd4;
                ifid_instr <= Instruction;
                ifid_pc    <= PC;
            end
            if (taken || load_use) begin
                idex_pc   <= '0;
                idex_a    <= '0;
                idex_b    <= '0;
                idex_imm  <= '0;
                idex_rs1  <= '0;
                idex_rs2  <= '0;
                idex_rd   <= '0;
                idex_ctrl <= '0;
            end else begin
                idex_pc   <= ifid_pc;
                idex_a    <= rs1_val;
                idex_b    <= rs2_val;
                idex_imm  <= dec_imm;
                idex_rs1  <= rs1;
                idex_rs2  <= rs2;
                idex_rd   <= rd;
                idex_ctrl <= dec_ctrl;
            end
            exmem_alu        <= alu_res;
            exmem_store      <= fwd_b;
            exmem_rd         <= idex_rd;
            exmem_reg_write  <= idex_ctrl.reg_write;
            exmem_mem_read   <= idex_ctrl.mem_read;
            exmem_mem_write  <= idex_ctrl.mem_write;
            memwb_alu        <= exmem_alu;
            memwb_load       <= dReadData;
            memwb_rd         <= exmem_rd;
            memwb_reg_write  <= exmem_reg_write;
            memwb_mem_to_reg <= exmem_mem_read;
        end
    end

    // Register file; x0 is never written
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (memwb_reg_write && memwb_rd != 5'd0) begin
            regs[memwb_rd] <= WriteBackData;
        end
    end
endmodule

// File: tb/tb_riscv_pipelined_datapath.sv
// Directed program bench for riscv_pipelined_datapath: hand-scheduled cycle
// checks of write-back values, memory strobes, PC redirects and reset.
module tb_riscv_pipelined_datapath;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] Instruction, PC, dAddress, dWriteData, dReadData, RO1, WriteBackData;
    logic        MemRead, MemWrite;

    logic [31:0] imem [0:63];
    logic [31:0] dmem [0:63];
    int n_compared   = 0;
    int n_mismatched = 0;
    int cyc          = 0;

    riscv_pipelined_datapath #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .Instruction(Instruction), .PC(PC),
        .dAddress(dAddress), .dWriteData(dWriteData), .dReadData(dReadData),
        .MemRead(MemRead), .MemWrite(MemWrite), .RO1(RO1), .WriteBackData(WriteBackData)
    );

    always #5 clk = ~clk;

    assign Instruction = imem[PC[7:2]];
    assign dReadData   = MemRead ? dmem[dAddress[7:2]] : 32'h0;

    always @(posedge clk) if (MemWrite) dmem[dAddress[7:2]] <= dWriteData;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
                                           input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, observed, expected);
        end
    endtask

    // Advance to the falling edge of cycle c (cycle 0 = before the first rising edge after reset)
    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
        #1;
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'h0000_0013;
            dmem[i] = 32'h0;
        end
        imem[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1);                 // ADDI x1,x0,5
        imem[1]  = enc_i(12'd7, 5'd0, 3'b000, 5'd2);                 // ADDI x2,x0,7
        imem[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);           // ADD x3,x1,x2
        imem[3]  = enc_sw(12'd0, 5'd3, 5'd0);                        // SW x3,0(x0)
        imem[4]  = {12'd0, 5'd0, 3'b010, 5'd4, 7'b0000011};          // LW x4,0(x0)
        imem[5]  = enc_r(7'h00, 5'd4, 5'd4, 3'b000, 5'd5);           // ADD x5,x4,x4
        imem[6]  = enc_b(13'd8, 5'd1, 5'd1, 3'b000);                 // BEQ x1,x1,+8
        imem[7]  = enc_i(12'd1, 5'd0, 3'b000, 5'd6);                 // ADDI x6,x0,1
        imem[8]  = enc_b(13'd8, 5'd1, 5'd1, 3'b001);                 // BNE x1,x1,+8
        imem[9]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd7);           // SUB x7,x1,x2
        imem[10] = enc_i({7'h20, 5'd1}, 5'd7, 3'b101, 5'd8);         // SRAI x8,x7,1
        imem[11] = enc_i({7'h00, 5'd1}, 5'd7, 3'b101, 5'd10);        // SRLI x10,x7,1
        imem[12] = enc_r(7'h00, 5'd7, 5'd1, 3'b010, 5'd11);          // SLT x11,x1,x7
        imem[13] = enc_r(7'h00, 5'd7, 5'd1, 3'b011, 5'd12);          // SLTU x12,x1,x7
        imem[14] = enc_i(12'd9, 5'd0, 3'b000, 5'd0);                 // ADDI x0,x0,9
        imem[15] = enc_r(7'h00, 5'd0, 5'd0, 3'b000, 5'd9);           // ADD x9,x0,x0
        imem[16] = enc_sw(12'd4, 5'd6, 5'd0);                        // SW x6,4(x0)
        imem[17] = enc_i(12'd3, 5'd0, 3'b000, 5'd14);                // ADDI x14,x0,3
        imem[18] = {20'h12345, 5'd16, 7'b0110111};                   // LUI x16,0x12345
        imem[20] = enc_i(12'd1, 5'd14, 3'b000, 5'd15);               // ADDI x15,x14,1

        repeat (2) @(negedge clk);
        #1;
        check("reset_pc", PC, 32'h0);
        check("reset_memread", 32'(MemRead), 32'h0);
        check("reset_memwrite", 32'(MemWrite), 32'h0);
        check("reset_daddr", dAddress, 32'h0);
        check("reset_dwdata", dWriteData, 32'h0);
        check("reset_wb", WriteBackData, 32'h0);

        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        goto(3);  check("pc_c3", PC, 32'd12);
        goto(4);  check("wb_addi_x1", WriteBackData, 32'd5);
        goto(5);  check("wb_addi_x2", WriteBackData, 32'd7);
        goto(6);  check("wb_add_x3", WriteBackData, 32'd12);
        check("sw_memwrite", 32'(MemWrite), 32'h1);
        check("sw_daddr", dAddress, 32'h0);
        check("sw_dwdata", dWriteData, 32'd12);
        check("sw_memread", 32'(MemRead), 32'h0);
        check("stall_pc_c6", PC, 32'd24);
        goto(7);  check("lw_memread", 32'(MemRead), 32'h1);
        check("lw_memwrite", 32'(MemWrite), 32'h0);
        check("stall_pc_c7", PC, 32'd24);
        goto(8);  check("wb_lw_x4", WriteBackData, 32'd12);
        check("pc_c8", PC, 32'd28);
        goto(9);  check("wb_bubble", WriteBackData, 32'd0);
        goto(10); check("wb_add_x5", WriteBackData, 32'd24);
        check("beq_target_pc", PC, 32'd32);
        goto(11); check("ro1_bne_x1", RO1, 32'd5);
        goto(12); check("wb_flushed_addi", WriteBackData, 32'd0);
        goto(13); check("bne_no_penalty_pc", PC, 32'd44);
        goto(15); check("wb_sub", WriteBackData, 32'hFFFF_FFFE);
        goto(16); check("wb_srai", WriteBackData, 32'hFFFF_FFFF);
        goto(17); check("wb_srli", WriteBackData, 32'h7FFF_FFFF);
        goto(18); check("wb_slt", WriteBackData, 32'd0);
        goto(19); check("wb_sltu", WriteBackData, 32'd1);
        goto(21); check("wb_add_x0", WriteBackData, 32'd0);
        check("sw_x6_memwrite", 32'(MemWrite), 32'h1);
        check("sw_x6_daddr", dAddress, 32'd4);
        check("sw_x6_flushed_val", dWriteData, 32'd0);
        goto(23); check("wb_addi_x14", WriteBackData, 32'd3);
        check("ro1_wb_bypass", RO1, 32'd3);
        goto(24); check("wb_lui", WriteBackData, 32'h1234_5000);
        goto(26); check("wb_addi_x15", WriteBackData, 32'd4);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        goto(6);  check("p2_sw_memwrite", 32'(MemWrite), 32'h1);
        #1 rst = 1'b0;
        #1;
        check("midrst_memwrite", 32'(MemWrite), 32'h0);
        check("midrst_pc", PC, 32'h0);
        check("midrst_daddr", dAddress, 32'h0);
        check("midrst_wb", WriteBackData, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        #1;
        check("restart_pc", PC, 32'h0);
        goto(4);  check("restart_wb_x1", WriteBackData, 32'd5);
        goto(6);  check("restart_wb_x3", WriteBackData, 32'd12);
        check("restart_sw_dwdata", dWriteData, 32'd12);
        goto(10); check("restart_wb_x5", WriteBackData, 32'd24);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
